// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and types shared by the I2S transmit and receive paths.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOTS  = 32;
    localparam int I2S_CNT_W  = 8;
    localparam int I2S_SLOT_W = $clog2(I2S_SLOTS);

    typedef logic signed [I2S_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Bit slot within the current channel for a given frame counter value.
    function automatic logic [I2S_SLOT_W-1:0] slot_of(input logic [I2S_CNT_W-1:0] c);
        return c[I2S_SLOT_W+1:2];
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: valid/ready stereo sample stream feeding the I2S transmitter.
interface i2s_tx_if #(
    parameter int DATA_W = 24
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: small synchronous FIFO of packed {left,right} frames.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module i2s_tx_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // The loader needs the head in the same cycle it decides to pop, so the
    // read is asynchronous; at this depth the array maps to distributed RAM.
    assign head = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers, wrapping naturally through the extra bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter. scki = clk, bck = clk/4, lrck = clk/256.
// One stereo frame is taken from the FIFO every lrck period; an empty FIFO
// yields a muted frame and an underrun pulse.
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun_cnt output.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W     = I2S_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nreset,
    i2s_tx_if.slave     s_bus,
    output logic        bck,
    output logic        lrck,
    output logic        scki,
    output logic        dout,
    output logic        frame_pop,
    output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam logic [I2S_CNT_W-1:0] CNT_LAST = '1;

    logic [I2S_CNT_W-1:0]  cnt_reg;
    logic [I2S_CNT_W-1:0]  cnt_next;
    logic                  frame_load;
    logic                  bit_tick;
    logic [I2S_SLOT_W-1:0] slot_next;
    logic                  chan_next;
    logic                  slot_active;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [2*DATA_W-1:0]   fifo_head;

    logic [DATA_W-1:0]     lsh_reg;
    logic [DATA_W-1:0]     rsh_reg;
    logic                  dout_reg;
    logic                  frame_pop_reg;
    logic                  underrun_reg;

    assign cnt_next    = cnt_reg + I2S_CNT_W'(1);
    assign frame_load  = (cnt_reg == CNT_LAST);
    // dout is launched one clk before each bck period starts (bck falling),
    // so everything is decided on the slot that begins at cnt_next.
    assign bit_tick    = (cnt_reg[1:0] == 2'b11);
    assign slot_next   = slot_of(cnt_next);
    assign chan_next   = cnt_next[I2S_CNT_W-1];
    assign slot_active = (slot_next != '0) && (int'(slot_next) <= DATA_W);

    assign fifo_push   = s_bus.s_valid & ~fifo_full;
    // No bypass: a push on the load edge is not visible to that load.
    assign fifo_pop    = frame_load & ~fifo_empty;
    assign s_bus.s_ready = ~fifo_full;

    assign scki      = clk;
    assign bck       = cnt_reg[1];
    assign lrck      = cnt_reg[I2S_CNT_W-1];
    assign dout      = dout_reg;
    assign frame_pop = frame_pop_reg;
    assign underrun  = underrun_reg;

    i2s_tx_fifo #(
        .W     (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (fifo_push),
        .push_data ({s_bus.s_left, s_bus.s_right}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Free-running frame counter; bck and lrck are taps of it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Frame load into the shift registers, then MSB-first shift-out per channel.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lsh_reg  <= '0;
            rsh_reg  <= '0;
            dout_reg <= 1'b0;
        end else begin
            if (frame_load) begin
                if (!fifo_empty) begin
                    {lsh_reg, rsh_reg} <= fifo_head;
                end else begin
                    lsh_reg <= '0;
                    rsh_reg <= '0;
                end
            end else if (bit_tick && slot_active) begin
                if (chan_next) begin
                    rsh_reg <= rsh_reg << 1;
                end else begin
                    lsh_reg <= lsh_reg << 1;
                end
            end
            if (bit_tick) begin
                dout_reg <= slot_active &
                            (chan_next ? rsh_reg[DATA_W-1] : lsh_reg[DATA_W-1]);
            end
        end
    end

    // One-cycle status pulses following each frame load.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            frame_pop_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            frame_pop_reg <= frame_load;
            underrun_reg  <= frame_load & fifo_empty;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    assign underrun_cnt = underrun_cnt_reg;

    // Saturating tally of muted frames.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            underrun_cnt_reg <= '0;
        end else if (frame_load && fifo_empty && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx. The stimulus side records every
// accepted push; the monitor models the FIFO as a queue drained once per
// 256-clk frame and checks the serial words, clocks and status pulses.
`timescale 1ns/1ps
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int DW = I2S_DATA_W;

    typedef struct {
        int            e;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } push_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          ur;
    } frame_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic bck, lrck, scki, dout, frame_pop, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int last_acc = 0;
    int frame_no = 0;

    push_t  pushq[$];
    frame_t expq[$];

    i2s_tx_if #(.DATA_W(DW)) bus ();

    i2s_tx #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .s_bus     (bus),
        .bck       (bck),
        .lrck      (lrck),
        .scki      (scki),
        .dout      (dout),
        .frame_pop (frame_pop),
        .underrun  (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; frame counter value = edge_n mod 256.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] cap_l, cap_r;
    bit started = 0;

    always @(negedge clk) begin : monitor
        int c;
        int slot;
        frame_t f;
        push_t p;
        if (!nreset) begin
            expq.delete();
            started = 0;
        end else if (edge_n > 0) begin
            c = edge_n % 256;
            check("bck", {31'd0, bck}, 32'((c >> 1) & 1));
            check("lrck", {31'd0, lrck}, 32'((c >> 7) & 1));
            check("scki", {31'd0, scki}, {31'd0, clk});
            if (c == 0) begin
                if (pushq.size() > 0 && pushq[0].e < edge_n) begin
                    p = pushq.pop_front();
                    f.l = p.l; f.r = p.r; f.ur = 1'b0;
                end else begin
                    f.l = '0; f.r = '0; f.ur = 1'b1;
                end
                expq.push_back(f);
                started = 1;
                check("frame_pop_pulse", {31'd0, frame_pop}, 32'd1);
                check("underrun_pulse", {31'd0, underrun}, {31'd0, f.ur});
            end else begin
                check("frame_pop_idle", {31'd0, frame_pop}, 32'd0);
                check("underrun_idle", {31'd0, underrun}, 32'd0);
            end
            if (started && (c % 4) == 2) begin
                slot = (c % 128) / 4;
                if (c < 128) cap_l[31-slot] = dout;
                else         cap_r[31-slot] = dout;
            end
            if (started && c == 254) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL frame_avail: no expected frame queued (edge %0d)", edge_n);
                end else begin
                    f = expq.pop_front();
                    check("left_word", cap_l, {1'b0, f.l, 7'b0});
                    check("right_word", cap_r, {1'b0, f.r, 7'b0});
                    frame_no++;
                    $display("frame %0d: L=%06h R=%06h expected L=%06h R=%06h underrun=%0b",
                             frame_no, cap_l[30:7], cap_r[30:7], f.l, f.r, f.ur);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_mod(input int m);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((edge_n % 256) != m && n < 600);
        if (n >= 600) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_timeout: waited %0d cycles for cnt %0h", n, m);
        end
    endtask

    task automatic push_sample(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n = 0;
        logic rdy;
        bit acc = 0;
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_left = l; bus.s_right = r;
        while (!acc && n < 1000) begin
            #1 rdy = bus.s_ready;
            @(posedge clk); #1;
            if (rdy === 1'b1) begin
                acc = 1;
                pushq.push_back('{edge_n, l, r});
                last_acc = edge_n;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: s_ready low for %0d cycles", n);
        end
    endtask

    task automatic apply_reset();
        nreset = 1'b0;
        bus.s_valid = 1'b0;
        pushq.delete();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.s_ready}, 32'd1);
        check("rst_frame_pop", {31'd0, frame_pop}, 32'd0);
        nreset = 1'b1;
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [DW-1:0] v;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        check("por_bck", {31'd0, bck}, 32'd0);
        check("por_lrck", {31'd0, lrck}, 32'd0);
        check("por_dout", {31'd0, dout}, 32'd0);
        check("por_underrun", {31'd0, underrun}, 32'd0);
        apply_reset();

        // Mid-frame reset at cnt 0x93: outputs drop immediately.
        wait_mod(0); wait_mod(0);
        wait_mod(8'h93);
        check("pre_rst_lrck", {31'd0, lrck}, 32'd1);
        nreset = 1'b0;
        #1;
        check("mid_rst_bck", {31'd0, bck}, 32'd0);
        check("mid_rst_lrck", {31'd0, lrck}, 32'd0);
        check("mid_rst_dout", {31'd0, dout}, 32'd0);
        check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.s_ready}, 32'd1);
        apply_reset();

        // Single frame pushed well ahead of the first load.
        repeat (10) @(posedge clk);
        push_sample(24'hA5A5A5, 24'h5A5A5A);

        // Idle frames: muted output with underrun pulses.
        wait_mod(0); wait_mod(0); wait_mod(0);

        // Backpressure: four fill the FIFO, the fifth waits for the next load.
        for (int i = 1; i <= 4; i++) push_sample(DW'(32'h100000 * i + 32'h11), DW'(32'h0F0000 + i));
        check("ready_full", {31'd0, bus.s_ready}, 32'd0);
        push_sample(24'h123ABC, 24'hFEDCBA);
        check("fifth_accept_cnt", 32'(last_acc % 256), 32'd1);

        // Streaming ramp, one push per frame, across pointer wrap.
        for (int n = 1; n <= 12; n++) begin
            wait_mod(0);
            push_sample(DW'(n), DW'(-n));
        end

        // Randomized pushes with random gaps.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            push_sample(DW'($urandom), DW'($urandom));
        end

        // Drain, then push exactly on the load edge with the FIFO empty.
        repeat (6) wait_mod(0);
        wait_mod(255);
        push_sample(24'h800001, 24'h7FFFFF);
        check("collision_cnt", 32'(last_acc % 256), 32'd0);
        wait_mod(0); wait_mod(0); wait_mod(0);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        apply_reset();
        check("ucnt_reset", {16'd0, underrun_cnt}, 32'd0);
        wait_mod(0); wait_mod(0); wait_mod(0);
        check("ucnt_three", {16'd0, underrun_cnt}, 32'd3);
        force dut.underrun_cnt_reg = 16'hFFFE;
        #1;
        release dut.underrun_cnt_reg;
        wait_mod(0); wait_mod(0);
        check("ucnt_saturate", {16'd0, underrun_cnt}, 32'hFFFF);
`endif

        v = '0;
        if (v != '0) $display("unreachable");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
